// File: rtl/permute_issue_ctrl_pkg.sv
// Shared definitions for the odd-pipe permute issue controller.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package perm_pkg;

    localparam int PERM_DEPTH = 3;

    localparam logic [0:10] OP_GBB     = 11'b00110110010; // gather bits from bytes
    localparam logic [0:10] OP_GBW     = 11'b00110110000; // gather bits from words
    localparam logic [0:10] OP_SHLQBY  = 11'b00111011111; // shift left qw by bytes
    localparam logic [0:10] OP_SHLQBYI = 11'b00111111111; // shift left qw by bytes imm
    localparam logic [0:10] OP_ROTQBY  = 11'b00111011100; // rotate qw by bytes
    localparam logic [0:10] OP_ROTQBYI = 11'b00111111100; // rotate qw by bytes imm
    localparam logic [0:10] OP_ROTQMBY = 11'b00111011101; // rotate+mask qw by bytes
    localparam logic [0:10] OP_ROTQMBYI= 11'b00111111101; // rotate+mask qw by bytes imm

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [0:10] opcode;
        logic [0:6]  ra;
        logic [0:6]  rb;
        logic [0:6]  rt;
        logic [0:6]  imm7;
    } perm_instr_t;

    function automatic logic is_perm_op(input logic [0:10] opcode);
        case (opcode)
            OP_GBB, OP_GBW, OP_SHLQBY, OP_SHLQBYI,
            OP_ROTQBY, OP_ROTQBYI, OP_ROTQMBY, OP_ROTQMBYI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // Only the register-count forms read RB; immediate forms carry the count in imm7.
    function automatic logic perm_uses_rb(input logic [0:10] opcode);
        case (opcode)
            OP_SHLQBY, OP_ROTQBY, OP_ROTQMBY: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/permute_issue_ctrl_scoreboard.sv
// In-flight tracker for the permute pipe: valid/rt shift register and RAW hazard check.
// Latency: issue at cycle I appears as wb_valid_o in cycle I+3; hazard_o is combinational.
// Backpressure: none; flush_i clears all in-flight valids on the next edge.
// Ports: issue_i/issue_rt_i enter stage 1; ra_i/rb_i/uses_rb_i describe the held
//        instruction; hazard_o, wb_valid_o, wb_rt_o report stage state.
module perm_scoreboard
    import perm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       issue_i,
    input  logic [0:6] issue_rt_i,
    input  logic [0:6] ra_i,
    input  logic [0:6] rb_i,
    input  logic       uses_rb_i,
    output logic       hazard_o,
    output logic       wb_valid_o,
    output logic [0:6] wb_rt_o
);

    logic [1:PERM_DEPTH]       v_q, v_d;
    logic [1:PERM_DEPTH][0:6]  rt_q, rt_d;

    always_comb begin
        v_d     = '0;
        rt_d    = '0;
        v_d[1]  = issue_i;
        rt_d[1] = issue_rt_i;
        for (int k = 2; k <= PERM_DEPTH; k++) begin
            v_d[k]  = v_q[k-1];
            rt_d[k] = rt_q[k-1];
        end
        // rt keeps shifting so wb_rt_o stays a plain register tap; only valids are killed.
        if (flush_i) begin
            v_d = '0;
        end
    end

    // Compared through the WB stage because the RF is written only at its end.
    always_comb begin
        hazard_o = 1'b0;
        for (int k = 1; k <= PERM_DEPTH; k++) begin
            if (v_q[k] && ((rt_q[k] == ra_i) || (uses_rb_i && (rt_q[k] == rb_i)))) begin
                hazard_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q  <= '0;
            rt_q <= '0;
        end else begin
            v_q  <= v_d;
            rt_q <= rt_d;
        end
    end

    assign wb_valid_o = v_q[PERM_DEPTH];
    assign wb_rt_o    = rt_q[PERM_DEPTH];

endmodule

// File: rtl/permute_issue_ctrl.sv
// Issue controller for the permute unit: one-entry buffer, RAW stall, WB-valid strobe.
// Latency: accept at T -> earliest issue at T+1; issue at I -> wb_valid at I+3.
// Backpressure: in_ready drops while the held op stalls on a hazard and during flush/reset.
// Ports: decode side in_*; RF read addresses rf_*; permute unit perm_*; writeback wb_*;
//        illegal_op pulse on a dropped non-permute opcode; saturating issue/stall counters.
module permute_issue_ctrl
    import perm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:10] in_opcode11,
    input  logic [0:6]  in_ra_addr,
    input  logic [0:6]  in_rb_addr,
    input  logic [0:6]  in_rt_addr,
    input  logic [0:6]  in_imm7,
    input  logic        flush,
    output logic [0:6]  rf_ra_addr,
    output logic [0:6]  rf_rb_addr,
    output logic [0:10] perm_opcode11,
    output logic [0:6]  perm_imm7,
    output logic [0:6]  perm_rt_addr,
    output logic        perm_issue,
    output logic        wb_valid,
    output logic [0:6]  wb_rt_addr,
    output logic        illegal_op,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);

    state_t      state_q, state_d;
    perm_instr_t buf_q, buf_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hazard;
    logic        run;
    logic        capture;
    logic        stall;

    perm_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .issue_i    (perm_issue),
        .issue_rt_i (buf_q.rt),
        .ra_i       (buf_q.ra),
        .rb_i       (buf_q.rb),
        .uses_rb_i  (perm_uses_rb(buf_q.opcode)),
        .hazard_o   (hazard),
        .wb_valid_o (wb_valid),
        .wb_rt_o    (wb_rt_addr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            buf_q       <= '0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d = HELD;
        end else if (perm_issue) begin
            state_d = EMPTY;
        end
        if (capture) begin
            buf_d = '{opcode: in_opcode11, ra: in_ra_addr, rb: in_rb_addr,
                      rt: in_rt_addr, imm7: in_imm7};
        end
        if (perm_issue && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Outputs; flush and reset both override any pending issue or accept.
    always_comb begin
        run        = reset && !flush;
        perm_issue = run && (state_q == HELD) && !hazard;
        stall      = run && (state_q == HELD) && hazard;
        in_ready   = run && ((state_q == EMPTY) || perm_issue);
        capture    = in_ready && in_valid && is_perm_op(in_opcode11);
        illegal_op = in_ready && in_valid && !is_perm_op(in_opcode11);
    end

    assign rf_ra_addr    = buf_q.ra;
    assign rf_rb_addr    = buf_q.rb;
    assign perm_opcode11 = perm_issue ? buf_q.opcode : 11'd0;
    assign perm_imm7     = buf_q.imm7;
    assign perm_rt_addr  = buf_q.rt;
    assign issue_cnt     = issue_cnt_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_permute_issue_ctrl.sv
// Bench for permute_issue_ctrl: vector table, directed multi-cycle sequences, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_permute_issue_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, flush;
    logic [0:10] in_opcode11, perm_opcode11;
    logic [0:6]  in_ra_addr, in_rb_addr, in_rt_addr, in_imm7;
    logic [0:6]  rf_ra_addr, rf_rb_addr, perm_imm7, perm_rt_addr, wb_rt_addr;
    logic        perm_issue, wb_valid, illegal_op;
    logic [15:0] issue_cnt, stall_cnt;

    permute_issue_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode11(in_opcode11), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_rt_addr(in_rt_addr), .in_imm7(in_imm7), .flush(flush),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .perm_opcode11(perm_opcode11),
        .perm_imm7(perm_imm7), .perm_rt_addr(perm_rt_addr), .perm_issue(perm_issue),
        .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .illegal_op(illegal_op),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    localparam logic [0:10] GBB = 11'b00110110010, GBW = 11'b00110110000;
    localparam logic [0:10] SHLQBY = 11'b00111011111, SHLQBYI = 11'b00111111111;
    localparam logic [0:10] ROTQBY = 11'b00111011100, ROTQBYI = 11'b00111111100;
    localparam logic [0:10] ROTQMBY = 11'b00111011101, ROTQMBYI = 11'b00111111101;

    logic [0:10] legal_ops [8];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: held instruction plus a list of issued ops stamped with issue cycle.
    typedef struct { int cyc; logic [0:6] rt; } flight_t;
    flight_t     fl[$];
    int          now = 0;
    bit          m_held;
    logic [0:10] m_op;
    logic [0:6]  m_ra, m_rb, m_rt, m_imm;
    int          m_issue_cnt, m_stall_cnt;
    bit          e_haz, e_issue, e_ready, e_ill, e_wb;
    logic [0:6]  e_wbrt;
    int          dut_issues[$];

    typedef struct {
        bit vld; logic [0:10] op; logic [0:6] ra, rb, rt, imm; bit fl;
        bit x_ready, x_issue, x_wb; logic [0:6] x_wbrt; bit x_ill;
    } vec_t;
    vec_t tbl[16];

    function automatic bit b_legal(input logic [0:10] op);
        for (int k = 0; k < 8; k++) if (op == legal_ops[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit b_uses_rb(input logic [0:10] op);
        return (op == SHLQBY) || (op == ROTQBY) || (op == ROTQMBY);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic drive(input bit v, input logic [0:10] op, input logic [0:6] ra,
                         input logic [0:6] rb, input logic [0:6] rt, input logic [0:6] imm,
                         input bit f);
        in_valid = v; in_opcode11 = op; in_ra_addr = ra; in_rb_addr = rb;
        in_rt_addr = rt; in_imm7 = imm; flush = f;
    endtask

    task automatic eval_cmp();
        #2;
        e_haz = 0; e_wb = 0; e_wbrt = '0;
        foreach (fl[i]) begin
            if ((now - fl[i].cyc) inside {[1:3]} &&
                ((fl[i].rt == m_ra) || (b_uses_rb(m_op) && fl[i].rt == m_rb))) e_haz = 1;
            if ((now - fl[i].cyc) == 3) begin e_wb = 1; e_wbrt = fl[i].rt; end
        end
        e_issue = reset && !flush && m_held && !e_haz;
        e_ready = reset && !flush && (!m_held || e_issue);
        e_ill   = e_ready && in_valid && !b_legal(in_opcode11);
        chk("in_ready", in_ready, e_ready);
        chk("perm_issue", perm_issue, e_issue);
        chk("illegal_op", illegal_op, e_ill);
        chk("wb_valid", wb_valid, e_wb);
        if (e_wb) chk("wb_rt_addr", wb_rt_addr, e_wbrt);
        chk("perm_opcode11", perm_opcode11, e_issue ? m_op : 11'd0);
        chk("perm_rt_addr", perm_rt_addr, m_rt);
        chk("perm_imm7", perm_imm7, m_imm);
        chk("rf_ra_addr", rf_ra_addr, m_ra);
        chk("rf_rb_addr", rf_rb_addr, m_rb);
        chk("issue_cnt", issue_cnt, m_issue_cnt);
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        if (perm_issue === 1'b1) dut_issues.push_back(now);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            fl.delete(); m_held = 0; m_op = '0; m_ra = '0; m_rb = '0; m_rt = '0; m_imm = '0;
            m_issue_cnt = 0; m_stall_cnt = 0;
        end else if (flush) begin
            fl.delete(); m_held = 0;
        end else begin
            if (e_issue) begin
                fl.push_back('{cyc: now, rt: m_rt});
                if (m_issue_cnt < 65535) m_issue_cnt++;
            end
            if (m_held && e_haz && m_stall_cnt < 65535) m_stall_cnt++;
            if (e_ready && in_valid && b_legal(in_opcode11)) begin
                m_held = 1; m_op = in_opcode11; m_ra = in_ra_addr; m_rb = in_rb_addr;
                m_rt = in_rt_addr; m_imm = in_imm7;
            end else if (e_issue) begin
                m_held = 0;
            end
        end
        now++;
        while (fl.size() > 0 && (now - fl[0].cyc) > 3) void'(fl.pop_front());
        #1;
    endtask

    task automatic step();
        eval_cmp();
        advance();
    endtask

    task automatic idle(input int n);
        drive(0, '0, '0, '0, '0, '0, 0);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 0;
        drive(0, '0, '0, '0, '0, '0, 0);
        advance();
        eval_cmp();
        chk("rst_wb_rt_addr", wb_rt_addr, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        advance();
        reset = 1;
        dut_issues.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        legal_ops = '{GBB, GBW, SHLQBY, SHLQBYI, ROTQBY, ROTQBYI, ROTQMBY, ROTQMBYI};
        //            vld op       ra    rb    rt    imm   fl  rdy iss wb wbrt  ill
        tbl[0]  = '{1, SHLQBYI, 7'd1, 7'd2, 7'd5, 7'd2, 0,  1,  0,  0, 7'd0, 0};
        tbl[1]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  1,  0, 7'd0, 0};
        tbl[2]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[3]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[4]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  1, 7'd5, 0};
        tbl[5]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[6]  = '{1, 11'd0,   7'd1, 7'd1, 7'd1, 7'd0, 0,  1,  0,  0, 7'd0, 1};
        tbl[7]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[8]  = '{1, ROTQBY,  7'd3, 7'd4, 7'd6, 7'd0, 1,  0,  0,  0, 7'd0, 0};
        tbl[9]  = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[10] = '{1, GBB,     7'd3, 7'd4, 7'd7, 7'd0, 0,  1,  0,  0, 7'd0, 0};
        tbl[11] = '{0, '0,      '0,   '0,   '0,   '0,   1,  0,  0,  0, 7'd0, 0};
        tbl[12] = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[13] = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[14] = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};
        tbl[15] = '{0, '0,      '0,   '0,   '0,   '0,   0,  1,  0,  0, 7'd0, 0};

        reset = 0;
        drive(0, '0, '0, '0, '0, '0, 0);
        @(posedge clk); #1;

        // Vector table: single op, illegal op, flush racing an offer and a pending issue.
        do_reset();
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].vld, tbl[r].op, tbl[r].ra, tbl[r].rb, tbl[r].rt, tbl[r].imm, tbl[r].fl);
            eval_cmp();
            chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].x_ready);
            chk($sformatf("tbl%0d_perm_issue", r), perm_issue, tbl[r].x_issue);
            chk($sformatf("tbl%0d_wb_valid", r), wb_valid, tbl[r].x_wb);
            if (tbl[r].x_wb) chk($sformatf("tbl%0d_wb_rt", r), wb_rt_addr, tbl[r].x_wbrt);
            chk($sformatf("tbl%0d_illegal_op", r), illegal_op, tbl[r].x_ill);
            advance();
        end

        // RAW on ra: dependent op issues exactly 4 cycles after its producer.
        do_reset();
        drive(1, ROTQBY, 7'd1, 7'd2, 7'd9, 7'd0, 0);  step();
        drive(1, ROTQBY, 7'd9, 7'd3, 7'd10, 7'd0, 0); step();
        idle(7);
        chk("raw_issues", dut_issues.size(), 2);
        if (dut_issues.size() == 2) chk("raw_gap", dut_issues[1] - dut_issues[0], 4);
        chk("raw_stall_cnt", stall_cnt, 3);

        // Streaming: 8 independent ops back-to-back.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, legal_ops[i], 7'(40 + i), 7'(50 + i), 7'(20 + i), 7'(i), 0);
            step();
        end
        idle(5);
        chk("stream_issues", dut_issues.size(), 8);
        if (dut_issues.size() == 8) chk("stream_span", dut_issues[7] - dut_issues[0], 7);
        chk("stream_issue_cnt", issue_cnt, 8);
        chk("stream_stall_cnt", stall_cnt, 0);

        // rb-only hazard stalls the register form, not the immediate form.
        do_reset();
        drive(1, ROTQBYI, 7'd1, 7'd0, 7'd12, 7'd3, 0); step();
        drive(1, SHLQBY, 7'd2, 7'd12, 7'd13, 7'd0, 0); step();
        drive(1, ROTQBYI, 7'd3, 7'd13, 7'd14, 7'd1, 0);
        repeat (4) step();
        idle(5);
        chk("rb_issues", dut_issues.size(), 3);
        if (dut_issues.size() == 3) begin
            chk("rb_gap_reg", dut_issues[1] - dut_issues[0], 4);
            chk("rb_gap_imm", dut_issues[2] - dut_issues[1], 1);
        end
        chk("rb_stall_cnt", stall_cnt, 3);

        // Flush after two issues kills both pending writebacks.
        do_reset();
        drive(1, GBW, 7'd1, 7'd2, 7'd30, 7'd0, 0); step();
        drive(1, GBB, 7'd3, 7'd4, 7'd31, 7'd0, 0); step();
        idle(1);
        drive(0, '0, '0, '0, '0, '0, 1); step();
        drive(0, '0, '0, '0, '0, '0, 0);
        for (int c = 0; c < 3; c++) begin
            eval_cmp();
            chk("flush_wb_valid", wb_valid, 0);
            chk("flush_in_ready", in_ready, 1);
            advance();
        end
        chk("flush_issue_cnt", issue_cnt, 2);

        // Reset during a stall.
        do_reset();
        drive(1, ROTQBY, 7'd1, 7'd2, 7'd9, 7'd0, 0);  step();
        drive(1, ROTQBY, 7'd9, 7'd3, 7'd10, 7'd0, 0); step();
        idle(1);
        reset = 0; step();
        eval_cmp();
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_wb_rt", wb_rt_addr, 0);
        chk("mid_rst_issue", perm_issue, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_issue_cnt", issue_cnt, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_rf_ra", rf_ra_addr, 0);
        advance();
        reset = 1;
        eval_cmp();
        chk("post_rst_ready", in_ready, 1);
        advance();
        idle(4);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 9) == 0) ? 11'($urandom) : legal_ops[$urandom_range(0, 7)],
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 7'($urandom),
                  $urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 99) != 0);
            step();
        end
        reset = 1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
